// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter and its
// pending-write scoreboard.
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int XLEN_DEF   = 64;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN_DEF-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the writeback request bus, register-file write port and the
// issue-stage reservation/busy lookups.
interface regfile_wb_arbiter_if
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = XLEN_DEF
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*REG_ADDR_W-1:0] req_rd;
  logic [NUM_REQ*XLEN-1:0]       req_data;
  logic [NUM_REQ-1:0]            req_ready;

  logic                          wb_we;
  logic [REG_ADDR_W-1:0]         wb_rd;
  logic [XLEN-1:0]               wb_data;

  logic                          issue_valid;
  logic [REG_ADDR_W-1:0]         issue_rd;
  logic                          issue_ready;
  logic [REG_ADDR_W-1:0]         rs1_addr;
  logic [REG_ADDR_W-1:0]         rs2_addr;
  logic                          rs1_busy;
  logic                          rs2_busy;

  modport slave (
    input  req_valid, req_rd, req_data, issue_valid, issue_rd, rs1_addr, rs2_addr,
    output req_ready, wb_we, wb_rd, wb_data, issue_ready, rs1_busy, rs2_busy
  );

  modport master (
    output req_valid, req_rd, req_data, issue_valid, issue_rd, rs1_addr, rs2_addr,
    input  req_ready, wb_we, wb_rd, wb_data, issue_ready, rs1_busy, rs2_busy
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write bits: reserves destinations at issue, releases
// them when the writeback commits, and answers source busy lookups.
module regfile_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid_i,
  input  logic [REG_ADDR_W-1:0] issue_rd_i,
  output logic                  issue_ready_o,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  output logic                  rs1_busy_o,
  output logic                  rs2_busy_o,
  input  logic                  clr_en_i,
  input  logic [REG_ADDR_W-1:0] clr_rd_i
);

  // Bit 0 is held at zero so x0 never stalls and never reads busy.
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  assign issue_ready_o = issue_valid_i & ~pending_q[issue_rd_i];
  assign rs1_busy_o    = pending_q[rs1_addr_i];
  assign rs2_busy_o    = pending_q[rs2_addr_i];

  always_comb begin
    pending_d = pending_q;
    if (clr_en_i) pending_d[clr_rd_i] = 1'b0;
    if (issue_ready_o && (issue_rd_i != '0)) pending_d[issue_rd_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates writeback requesters onto the single register-file write port
// through a registered output stage. Define RR_ARB_EN for round-robin
// arbitration; otherwise the lowest-indexed valid requester wins.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = XLEN_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    gnt;
  logic                  gnt_any;
  logic [PTR_W-1:0]      gnt_idx;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]       sel_data;

`ifdef RR_ARB_EN
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  function automatic int rr_idx(input int start, input int ofs);
    return (start + ofs) % NUM_REQ;
  endfunction

  // ptr_q names the requester searched first: the one after the last grant.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_any && bus.req_valid[rr_idx(int'(ptr_q), k)]) begin
        gnt_any = 1'b1;
        gnt_idx = PTR_W'(rr_idx(int'(ptr_q), k));
        gnt[rr_idx(int'(ptr_q), k)] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_any && bus.req_valid[k]) begin
        gnt_any = 1'b1;
        gnt_idx = PTR_W'(k);
        gnt[k]  = 1'b1;
      end
    end
  end
`endif

  assign bus.req_ready = gnt;
  assign sel_rd        = bus.req_rd[gnt_idx*REG_ADDR_W +: REG_ADDR_W];
  assign sel_data      = bus.req_data[gnt_idx*XLEN +: XLEN];

  // Output stage: a grant to x0 is consumed but never raises the write enable.
  logic                  wb_we_q,   wb_we_d;
  logic [REG_ADDR_W-1:0] wb_rd_q,   wb_rd_d;
  logic [XLEN-1:0]       wb_data_q, wb_data_d;

  always_comb begin
    wb_we_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    if (gnt_any) begin
      wb_we_d   = (sel_rd != '0);
      wb_rd_d   = sel_rd;
      wb_data_d = sel_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_we_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      wb_we_q   <= wb_we_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign bus.wb_we   = wb_we_q;
  assign bus.wb_rd   = wb_rd_q;
  assign bus.wb_data = wb_data_q;

  // The pending bit clears on the same edge the register file captures wb_data.
  regfile_scoreboard u_sb (
    .clk           (clk),
    .reset         (reset),
    .issue_valid_i (bus.issue_valid),
    .issue_rd_i    (bus.issue_rd),
    .issue_ready_o (bus.issue_ready),
    .rs1_addr_i    (bus.rs1_addr),
    .rs2_addr_i    (bus.rs2_addr),
    .rs1_busy_o    (bus.rs1_busy),
    .rs2_busy_o    (bus.rs2_busy),
    .clr_en_i      (wb_we_q),
    .clr_rd_i      (wb_rd_q)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a per-cycle reference model queues
// expected grants/lookups and expected write-port contents; monitors compare.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int XLEN    = XLEN_DEF;

  typedef struct packed {
    logic    we;
    wb_req_t req;
  } out_t;

  typedef struct packed {
    logic [NUM_REQ-1:0] gnt;
    logic               ir;
    logic               b1;
    logic               b2;
  } comb_t;

  logic clk;
  logic reset;

  regfile_wb_arbiter_if #(.NUM_REQ(NUM_REQ), .XLEN(XLEN)) bus ();

  regfile_wb_arbiter #(.NUM_REQ(NUM_REQ), .XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  out_t  oq[$];
  comb_t cq[$];

  // Reference model state
  bit              pend[32];
  out_t            out_m;
  int              last_g;

  // Requesters' outstanding requests (held until granted)
  bit              r_v   [NUM_REQ];
  logic [4:0]      r_rd  [NUM_REQ];
  logic [XLEN-1:0] r_data[NUM_REQ];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] rand_data();
    return XLEN'({$urandom(), $urandom()});
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) pend[i] = 1'b0;
    out_m  = '0;
    last_g = NUM_REQ - 1;
    for (int i = 0; i < NUM_REQ; i++) r_v[i] = 1'b0;
  endtask

  function automatic bit any_req();
    bit a = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) a |= r_v[i];
    return a;
  endfunction

  // One clock cycle of stimulus plus the model's prediction for it.
  task automatic step(input bit iv, input logic [4:0] ird, input logic [4:0] a1,
                      input logic [4:0] a2, input bit rpulse);
    int    g;
    comb_t c;
    @(negedge clk);
    if (rpulse) begin
      reset = 1'b1;
      model_reset();
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_valid[i]             = r_v[i];
      bus.req_rd[5*i +: 5]         = r_rd[i];
      bus.req_data[XLEN*i +: XLEN] = r_data[i];
    end
    bus.issue_valid = iv;
    bus.issue_rd    = ird;
    bus.rs1_addr    = a1;
    bus.rs2_addr    = a2;
    #1;
    g = -1;
`ifdef RR_ARB_EN
    for (int k = 1; k <= NUM_REQ; k++)
      if (g < 0 && r_v[(last_g + k) % NUM_REQ]) g = (last_g + k) % NUM_REQ;
`else
    for (int k = 0; k < NUM_REQ; k++)
      if (g < 0 && r_v[k]) g = k;
`endif
    c.gnt = '0;
    if (g >= 0) c.gnt[g] = 1'b1;
    c.ir = iv && (ird == 0 || !pend[ird]);
    c.b1 = (a1 != 0) && pend[a1];
    c.b2 = (a2 != 0) && pend[a2];
    cq.push_back(c);
    if (out_m.we) pend[out_m.req.rd] = 1'b0;
    if (c.ir && ird != 0) pend[ird] = 1'b1;
    if (g >= 0) begin
      out_m.we       = (r_rd[g] != 0);
      out_m.req.rd   = r_rd[g];
      out_m.req.data = r_data[g];
      last_g         = g;
      r_v[g]         = 1'b0;
    end else begin
      out_m.we = 1'b0;
    end
    oq.push_back(out_m);
    if (rpulse) begin
      #2;
      reset = 1'b0;
    end
  endtask

  task automatic set_req(input int i, input logic [4:0] rd, input logic [XLEN-1:0] d);
    r_v[i]    = 1'b1;
    r_rd[i]   = rd;
    r_data[i] = d;
  endtask

  // Monitor: combinational responses, sampled mid low phase
  initial begin
    comb_t c;
    forever begin
      @(negedge clk);
      #2;
      if (cq.size() > 0) begin
        c = cq.pop_front();
        chk("req_ready",   64'(bus.req_ready),   64'(c.gnt));
        chk("issue_ready", 64'(bus.issue_ready), 64'(c.ir));
        chk("rs1_busy",    64'(bus.rs1_busy),    64'(c.b1));
        chk("rs2_busy",    64'(bus.rs2_busy),    64'(c.b2));
      end
    end
  end

  // Monitor: registered write port, sampled just after the active edge
  initial begin
    out_t e;
    forever begin
      @(posedge clk);
      #1;
      if (oq.size() > 0) begin
        e = oq.pop_front();
        chk("wb_we",   64'(bus.wb_we),   64'(e.we));
        chk("wb_rd",   64'(bus.wb_rd),   64'(e.req.rd));
        chk("wb_data", 64'(bus.wb_data), 64'(e.req.data));
      end
    end
  end

  initial begin
    reset           = 1'b1;
    bus.req_valid   = '0;
    bus.req_rd      = '0;
    bus.req_data    = '0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
    bus.rs1_addr    = '0;
    bus.rs2_addr    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      r_rd[i]   = '0;
      r_data[i] = '0;
    end
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    step(0, 0, 1, 2, 0);

    // Single writeback from requester 1, then an x0 write
    set_req(1, 5'd5, XLEN'(64'hDEAD_BEEF));
    step(0, 0, 5, 0, 0);
    set_req(0, 5'd0, rand_data());
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Contention: both requesters valid for four cycles
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (!r_v[i]) set_req(i, 5'(10 + 4*n + i), rand_data());
      step(0, 0, 0, 0, 0);
    end
    for (int k = 0; k < 10 && any_req(); k++) step(0, 0, 0, 0, 0);

    // RAW / WAW on register 7
    step(1, 7, 7, 0, 0);
    step(0, 0, 7, 0, 0);
    step(1, 7, 7, 0, 0);
    set_req(0, 5'd7, rand_data());
    step(1, 7, 7, 0, 0);
    step(1, 7, 7, 0, 0);
    step(1, 7, 7, 0, 0);
    step(0, 0, 7, 0, 0);
    set_req(0, 5'd7, rand_data());
    step(0, 0, 7, 0, 0);
    step(0, 0, 7, 0, 0);
    step(0, 0, 7, 0, 0);

    // Set of reg 3 in the same cycle as the clear of reg 9
    step(1, 9, 9, 0, 0);
    set_req(0, 5'd9, rand_data());
    step(0, 0, 9, 0, 0);
    step(1, 3, 3, 9, 0);
    step(0, 0, 3, 9, 0);

    // Reset pulse while a write is in flight and a register is pending
    step(1, 12, 12, 3, 0);
    set_req(0, 5'd4, XLEN'(64'h1234_5678_9ABC_DEF0));
    step(0, 0, 12, 4, 0);
    step(0, 0, 12, 3, 1);
    for (int a = 0; a < 32; a++) step(0, 0, 5'(a), 5'(31 - a), 0);
    set_req(0, 5'd21, rand_data());
    set_req(1, 5'd22, rand_data());
    step(0, 0, 0, 0, 0);
    for (int k = 0; k < 10 && any_req(); k++) step(0, 0, 0, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (!r_v[i] && $urandom_range(0, 1) == 1) set_req(i, 5'($urandom_range(0, 9)), rand_data());
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 9)),
           5'($urandom_range(0, 9)), 5'($urandom_range(0, 31)), 0);
    end
    for (int k = 0; k < 20 && any_req(); k++) step(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #3;
    chk("queues_drained", 64'(oq.size() + cq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
